emu_scan_ctrl: RTL and testbench
================================

Name: emu_scan_ctrl

Overview:
- Hardware host-side controller for the emulator checkpoint scan chains.
- On a command it pauses the DUT, then either dumps or restores the chains, then releases pause.
  - Dump: shifts out the FF chain, then the RAM chain, streaming words to the host.
  - Restore: streams host words into the FF chain, then the RAM chain.
- Sits between the platform DMA/host stream and the EMU_DUT scan ports. It replaces the bench-driven scan sequencing with a handshaked block.

Parameters:
- DATA_WIDTH, 64, scan word width (SDI/SDO and stream width).
- FF_WORDS, 4, number of FF chain words (CHAIN_FF_WORDS); must be >=1.
- MEM_WORDS, 8, number of RAM chain words (CHAIN_MEM_WORDS); must be >=1.
- BUF_DEPTH, 16, internal FIFO depth, power of two; must be >= MEM_WORDS.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_dir  in  1  0=dump, 1=restore; sampled on cmd handshake.
- busy  out  1  high from command accept until DONE.
- done  out  1  one-cycle pulse at end of operation.
- dout_valid / dout_ready / dout_data  out/in/out  1/1/DATA_WIDTH  dump word stream from FIFO head.
- din_valid / din_ready / din_data  in/out/in  1/1/DATA_WIDTH  restore word stream.
- emu_pause  out  1  drives $EMU$PAUSE.
- ff_scan  out  1  drives $EMU$FF$SCAN.
- ff_sdi  out  DATA_WIDTH  drives $EMU$FF$SDI.
- ff_sdo  in  DATA_WIDTH  from $EMU$FF$SDO.
- ram_scan  out  1  drives $EMU$RAM$SCAN.
- ram_dir  out  1  drives $EMU$RAM$DIR.
- ram_sdi  out  DATA_WIDTH  drives $EMU$RAM$SDI.
- ram_sdo  in  DATA_WIDTH  from $EMU$RAM$SDO.

Behaviour:
- Reset values (all outputs and state, asynchronously on resetn low): cmd_ready=1; busy, done, emu_pause, ff_scan, ram_scan, ram_dir=0; dout_valid=0; din_ready=0; FIFO empty; state IDLE.
- ff_sdi = dir ? din_data : ff_sdo (combinational). In dump the FF chain recirculates so its contents are preserved.
- IDLE: on cmd_valid&cmd_ready latch dir, set busy and emu_pause -> PAUSE.
- PAUSE: one cycle, no scan -> FF.
- FF: word counter 0..FF_WORDS-1. A word transfers on a cycle with ff_scan=1.
  - Dump: ff_scan = !fifo_full. Each transfer pushes ff_sdo to the FIFO.
  - Restore: ff_scan = din_valid and din_ready = 1. Each transfer consumes din.
  - Stalls drop ff_scan, so the chain does not shift. After the last word -> RAM_PREP.
- RAM_PREP: the RAM chain is never stalled once started.
  - Dump: wait until the FIFO is empty (host drained).
  - Restore: accept din into the FIFO (din_ready = !fifo_full) until it holds MEM_WORDS words.
  - Then -> RAM_LAT with ram_scan=1, ram_dir=dir.
- RAM_LAT, dump: 2 cycles of ram_scan=1 (SDO pipeline latency). Restore: 0 cycles.
- RAM_XFER: MEM_WORDS consecutive cycles with ram_scan=1.
  - Dump: push ram_sdo each cycle.
  - Restore: pop the FIFO head onto ram_sdi each cycle.
- RAM_HOLD, restore only: 1 extra cycle with ram_scan=1, ram_sdi don't-care.
- RESUME: ram_scan=0 for 1 cycle, pause still high; then emu_pause=0 -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- dout_valid = !fifo_empty in dump mode only. The host may drain throughout FF and RAM phases.
- Dump finishes only when the FIFO is empty: DONE waits for the drain.
- cmd_valid while busy is ignored (cmd_ready=0).
- Reset mid-operation returns to IDLE with pause released. Chain contents are then undefined and that is accepted.
- Counters are clog2(max(FF_WORDS,MEM_WORDS)+1) wide; no wrap.

Decomposition:
- Package emu_scan_pkg: state enum (IDLE, PAUSE, FF, RAM_PREP, RAM_LAT, RAM_XFER, RAM_HOLD, RESUME, DONE), DIR_DUMP/DIR_RESTORE constants, RAM_SDO_LATENCY=2.
- One sub-module emu_scan_fifo: synchronous FIFO, DATA_WIDTH x BUF_DEPTH, push/pop/full/empty/count, async active-low reset.

Test Plan:
- Dump, dout_ready=1: emu_pause rises 1 cycle after accept; ff_scan high for exactly 4 cycles; ram_scan high 2+8=10 cycles; 12 dout words matching the DUT-internal chain; done 1 pulse; pause low before done.
- Dump with dout_ready toggling 1-in-3: ff_scan gaps appear, FF chain contents unchanged after the op (a second dump gives identical words); ram_scan stays continuous for 10 cycles.
- Restore with 12 words from a prior dump, din_valid=1: ff_scan 4 cycles, ram_scan 9 cycles, ram_sdi sequence equals words 4..11; after done the DUT rdata and mem[0..7] equal the saved values.
- Restore with din_valid gapped: ram_scan does not rise until the FIFO holds 8 words; no bubble in ram_sdi during RAM_XFER.
- cmd_valid held during an operation: no second start; cmd_ready=0 until the cycle after done.
- resetn pulsed low during RAM_XFER: all outputs return to reset values immediately; a new dump then completes normally.

Source files
------------

// File: rtl/emu_scan_pkg.sv
// Shared constants for the emulator checkpoint scan controller: FSM encoding,
// transfer direction and RAM chain read latency.
package emu_scan_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_PAUSE    = 4'd1;
    localparam logic [3:0] ST_FF       = 4'd2;
    localparam logic [3:0] ST_RAM_PREP = 4'd3;
    localparam logic [3:0] ST_RAM_LAT  = 4'd4;
    localparam logic [3:0] ST_RAM_XFER = 4'd5;
    localparam logic [3:0] ST_RAM_HOLD = 4'd6;
    localparam logic [3:0] ST_RESUME   = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    localparam logic DIR_DUMP    = 1'b0;
    localparam logic DIR_RESTORE = 1'b1;

    localparam int RAM_SDO_LATENCY = 2;

endpackage

// File: rtl/emu_scan_fifo.sv
// Synchronous FIFO, DATA_WIDTH x DEPTH, head word visible combinationally.
// Push while full and pop while empty are ignored.
module emu_scan_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/emu_scan_ctrl.sv
// Pauses the emulated DUT and dumps or restores its FF and RAM scan chains.
// FF chain stalls under backpressure; RAM chain runs unstalled once primed.
module emu_scan_ctrl
    import emu_scan_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FF_WORDS   = 4,
    parameter int MEM_WORDS  = 8,
    parameter int BUF_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    output logic                  busy,
    output logic                  done,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_data,
    output logic                  emu_pause,
    output logic                  ff_scan,
    output logic [DATA_WIDTH-1:0] ff_sdi,
    input  logic [DATA_WIDTH-1:0] ff_sdo,
    output logic                  ram_scan,
    output logic                  ram_dir,
    output logic [DATA_WIDTH-1:0] ram_sdi,
    input  logic [DATA_WIDTH-1:0] ram_sdo
);
    localparam int CW = $clog2(((FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS) + 1);
    localparam int QW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] FF_LAST  = CW'(FF_WORDS - 1);
    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_WORDS - 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(RAM_SDO_LATENCY - 1);
    localparam logic [QW-1:0] MEM_FILL = QW'(MEM_WORDS);

    logic [3:0]            state_q, state_d;
    logic                  dir_q, dir_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  f_push, f_pop, f_full, f_empty;
    logic [DATA_WIDTH-1:0] f_push_dat, f_head;
    logic [QW-1:0]         f_count;

    emu_scan_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (f_push),
        .push_data (f_push_dat),
        .pop       (f_pop),
        .pop_data  (f_head),
        .full      (f_full),
        .empty     (f_empty),
        .count     (f_count)
    );

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign emu_pause  = busy;
    assign done       = (state_q == ST_DONE) && f_empty;
    assign ram_dir    = ram_scan & dir_q;
    assign ff_sdi     = (dir_q == DIR_RESTORE) ? din_data : ff_sdo;
    assign ram_sdi    = f_head;
    assign dout_data  = f_head;
    assign dout_valid = (dir_q == DIR_DUMP) && !f_empty;
    assign f_pop      = (dir_q == DIR_DUMP) ? (dout_valid & dout_ready)
                                            : (state_q == ST_RAM_XFER);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        ff_scan    = 1'b0;
        din_ready  = 1'b0;
        ram_scan   = 1'b0;
        f_push     = 1'b0;
        f_push_dat = ff_sdo;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                cnt_d   = '0;
                state_d = ST_FF;
            end
            ST_FF: begin
                if (dir_q == DIR_DUMP) begin
                    ff_scan = !f_full;
                    f_push  = ff_scan;
                end else begin
                    ff_scan   = din_valid;
                    din_ready = 1'b1;
                end
                if (ff_scan) begin
                    if (cnt_q == FF_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RAM_PREP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RAM_PREP: begin
                // RAM chain cannot stall, so buffer space/data is secured first.
                if (dir_q == DIR_DUMP) begin
                    if (f_empty) begin
                        state_d = ST_RAM_LAT;
                    end
                end else begin
                    din_ready  = !f_full && (f_count < MEM_FILL);
                    f_push     = din_valid && din_ready;
                    f_push_dat = din_data;
                    if (f_count == MEM_FILL) begin
                        state_d = ST_RAM_XFER;
                    end
                end
                cnt_d = '0;
            end
            ST_RAM_LAT: begin
                ram_scan = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RAM_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RAM_XFER: begin
                ram_scan = 1'b1;
                if (dir_q == DIR_DUMP) begin
                    f_push     = 1'b1;
                    f_push_dat = ram_sdo;
                end
                if (cnt_q == MEM_LAST) begin
                    cnt_d   = '0;
                    state_d = (dir_q == DIR_RESTORE) ? ST_RAM_HOLD : ST_RESUME;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RAM_HOLD: begin
                ram_scan = 1'b1;
                state_d  = ST_RESUME;
            end
            ST_RESUME: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // A dump is only complete once the host has drained the buffer.
                if (f_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_DUMP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_emu_scan_ctrl.sv
// Scoreboard bench for emu_scan_ctrl with a behavioural model of the emulator
// FF chain (recirculating shift register) and RAM chain (2-cycle read latency).
module tb_emu_scan_ctrl;
    localparam int DW  = 64;
    localparam int FFW = 4;
    localparam int MW  = 8;
    localparam int BD  = 16;
    localparam int NW  = FFW + MW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid, cmd_ready, cmd_dir, busy, done;
    logic          dout_valid, dout_ready;
    logic [DW-1:0] dout_data;
    logic          din_valid, din_ready;
    logic [DW-1:0] din_data;
    logic          emu_pause, ff_scan, ram_scan, ram_dir;
    logic [DW-1:0] ff_sdi, ff_sdo, ram_sdi, ram_sdo;

    always #5 clk = ~clk;

    emu_scan_ctrl #(
        .DATA_WIDTH (DW),
        .FF_WORDS   (FFW),
        .MEM_WORDS  (MW),
        .BUF_DEPTH  (BD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .busy       (busy),
        .done       (done),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .emu_pause  (emu_pause),
        .ff_scan    (ff_scan),
        .ff_sdi     (ff_sdi),
        .ff_sdo     (ff_sdo),
        .ram_scan   (ram_scan),
        .ram_dir    (ram_dir),
        .ram_sdi    (ram_sdi),
        .ram_sdo    (ram_sdo)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Golden chain contents and emulator chain model
    logic [DW-1:0] gold_ff  [FFW];
    logic [DW-1:0] gold_mem [MW];
    logic [DW-1:0] ff_chain [FFW];
    logic [DW-1:0] mem_m    [MW];
    logic [DW-1:0] p1, p2;
    int            r_addr = 0, w_addr = 0;
    logic          mdl_load = 1'b0, mdl_scramble = 1'b0;

    assign ff_sdo  = ff_chain[0];
    assign ram_sdo = p2;

    always @(posedge clk) begin
        if (mdl_load || mdl_scramble) begin
            for (int i = 0; i < FFW; i++) ff_chain[i] <= mdl_load ? gold_ff[i] : ~gold_ff[i];
            for (int i = 0; i < MW; i++)  mem_m[i]    <= mdl_load ? gold_mem[i] : ~gold_mem[i];
        end else begin
            if (ff_scan) begin
                for (int i = 0; i < FFW - 1; i++) ff_chain[i] <= ff_chain[i+1];
                ff_chain[FFW-1] <= ff_sdi;
            end
            if (ram_scan && !ram_dir) begin
                p1     <= (r_addr < MW) ? mem_m[r_addr] : '0;
                p2     <= p1;
                r_addr <= r_addr + 1;
            end else begin
                r_addr <= 0;
            end
            if (ram_scan && ram_dir) begin
                if (w_addr < MW) mem_m[w_addr] <= ram_sdi;
                w_addr <= w_addr + 1;
            end else begin
                w_addr <= 0;
            end
        end
    end

    // Scoreboard queues and per-operation statistics
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sdi_q[$];
    logic [DW-1:0] got_words [NW];
    logic [DW-1:0] mon_e;
    int   ff_cyc, ram_cyc, ram_rise, dout_n, done_n, din_n, acc_n, ram_wr_n;
    logic ram_prev = 1'b0;
    logic cur_dir  = 1'b0;
    int   rdy_mode = 0;

    task automatic clear_stats();
        ff_cyc = 0; ram_cyc = 0; ram_rise = 0; dout_n = 0;
        done_n = 0; din_n = 0; acc_n = 0; ram_wr_n = 0;
    endtask

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_n++;
        if (busy) chk("rdy_busy", cmd_ready, 0);
        if (ff_scan) ff_cyc++;
        if (ram_scan) begin
            ram_cyc++;
            if (!ram_prev) begin
                ram_rise++;
                if (ram_dir) chk("ram_start_fill", din_n, NW);
            end
            chk("ram_dir", ram_dir, cur_dir);
        end
        ram_prev = ram_scan;
        if (ram_scan && ram_dir) begin
            if (ram_wr_n < MW) begin
                mon_e = (sdi_q.size() != 0) ? sdi_q.pop_front() : {DW{1'bx}};
                chk("ram_sdi", ram_sdi, mon_e);
            end
            ram_wr_n++;
        end
        if (din_valid && din_ready) din_n++;
        if (dout_valid && dout_ready) begin
            mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : {DW{1'bx}};
            chk("dout", dout_data, mon_e);
            if (dout_n < NW) got_words[dout_n] = dout_data;
            dout_n++;
        end
        if (done) begin
            done_n++;
            chk("pause_at_done", emu_pause, 0);
            chk("rdy_at_done", cmd_ready, 0);
        end
    end

    // Host drain pattern: always ready, or ready one cycle in three
    initial begin
        int ph;
        ph = 0;
        dout_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ph = (ph + 1) % 3;
            dout_ready = (rdy_mode == 0) ? 1'b1 : (ph == 0);
        end
    end

    task automatic issue_cmd(input logic dir, input bit hold);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        chk("pause_pre", emu_pause, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #1;
        chk("pause_rise", emu_pause, 1);
        chk("busy_rise", busy, 1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_n == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", (done_n > 0), 1);
    endtask

    task automatic push_dump_exp();
        for (int i = 0; i < FFW; i++) exp_q.push_back(gold_ff[i]);
        for (int i = 0; i < MW; i++)  exp_q.push_back(gold_mem[i]);
    endtask

    task automatic run_dump(input int mode, input bit hold);
        rdy_mode = mode;
        clear_stats();
        cur_dir = 1'b0;
        push_dump_exp();
        issue_cmd(1'b0, hold);
        wait_done(3000);
        if (hold) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("dump_ff_cyc", ff_cyc, FFW);
        chk("dump_ram_cyc", ram_cyc, 2 + MW);
        chk("dump_ram_rise", ram_rise, 1);
        chk("dump_words", dout_n, NW);
        chk("dump_done_n", done_n, 1);
        chk("dump_left", exp_q.size(), 0);
        chk("dump_accepts", acc_n, 1);
        rdy_mode = 0;
    endtask

    task automatic run_restore(input bit gap);
        logic [DW-1:0] words [NW];
        int  idx, cyc;
        bit  hs;
        for (int i = 0; i < NW; i++) words[i] = got_words[i];
        @(posedge clk); #1 mdl_scramble = 1'b1;
        @(posedge clk); #1 mdl_scramble = 1'b0;
        chk("scrambled", ff_chain[0], ~gold_ff[0]);
        clear_stats();
        cur_dir = 1'b1;
        for (int i = FFW; i < NW; i++) sdi_q.push_back(words[i]);
        issue_cmd(1'b1, 1'b0);
        idx = 0; cyc = 0; hs = 1'b0;
        while (done_n == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            if (hs) idx++;
            din_valid = (idx < NW) && (gap ? ($urandom_range(0, 2) != 0) : 1'b1);
            din_data  = (idx < NW) ? words[idx] : '0;
            @(negedge clk); #1;
            hs = din_valid && din_ready;
            cyc++;
        end
        din_valid = 1'b0;
        chk("done_seen", (done_n > 0), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ff_cyc", ff_cyc, FFW);
        chk("rst_ram_cyc", ram_cyc, MW + 1);
        chk("rst_ram_rise", ram_rise, 1);
        chk("rst_din_n", din_n, NW);
        chk("rst_done_n", done_n, 1);
        chk("rst_sdi_left", sdi_q.size(), 0);
        for (int i = 0; i < FFW; i++) chk("rst_ff_chain", ff_chain[i], gold_ff[i]);
        for (int i = 0; i < MW; i++)  chk("rst_mem", mem_m[i], gold_mem[i]);
    endtask

    task automatic check_idle_outputs();
        chk("o_cmd_ready", cmd_ready, 1);
        chk("o_busy", busy, 0);
        chk("o_done", done, 0);
        chk("o_pause", emu_pause, 0);
        chk("o_ff_scan", ff_scan, 0);
        chk("o_ram_scan", ram_scan, 0);
        chk("o_ram_dir", ram_dir, 0);
        chk("o_dout_valid", dout_valid, 0);
        chk("o_din_ready", din_ready, 0);
    endtask

    initial begin
        int n;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        din_valid = 1'b0;
        din_data  = '0;
        clear_stats();
        for (int i = 0; i < FFW; i++) gold_ff[i]  = {$urandom, $urandom};
        for (int i = 0; i < MW; i++)  gold_mem[i] = {$urandom, $urandom};
        mdl_load = 1'b1;
        @(posedge clk); #1 mdl_load = 1'b0;
        check_idle_outputs();
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        run_dump(0, 1'b0);
        run_dump(1, 1'b0);
        run_restore(1'b0);
        run_restore(1'b1);
        run_dump(0, 1'b1);

        // Reset in the middle of the RAM transfer
        clear_stats();
        cur_dir = 1'b0;
        push_dump_exp();
        issue_cmd(1'b0, 1'b0);
        n = 0;
        while (ram_cyc < 4 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_ram_reached", (ram_cyc >= 4), 1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check_idle_outputs();
        repeat (2) @(posedge clk);
        #2;
        exp_q.delete();
        resetn = 1'b1;
        run_dump(0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
